// File: rtl/ucie_debug_trace_ctrl.sv
// Round-robin trace arbiter, timestamping write pipeline and capture sequencer for the debug trace
// buffer. Define UCIE_DEBUG_TRACE_DEDUP_EN to suppress entries repeating the last written one.
//
// state | meaning
// IDLE  | not capturing; producers sunk, nothing written
// ARMED | circular pre-trigger capture, watching the masked trigger
// POST  | counting post-trigger entries toward post_trig_len
// DONE  | buffer frozen for controller readback
module ucie_debug_trace_ctrl #(
  parameter int NUM_SRC   = 4,
  parameter int DEPTH     = 256,
  parameter int PAYLOAD_W = 24,
  localparam int AW = $clog2(DEPTH),
  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         debug_capture_enable,
  input  logic [31:0]                  debug_trigger_mask,
  input  logic [31:0]                  trig_events,
  input  logic                         arm,
  input  logic [AW-1:0]                post_trig_len,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic [NUM_SRC*PAYLOAD_W-1:0] src_data,
  output logic [NUM_SRC-1:0]           src_ready,
  output logic                         buf_we,
  output logic [AW-1:0]                buf_waddr,
  output logic [63:0]                  buf_wdata,
  output logic [AW-1:0]                debug_trace_ptr,
  output logic [31:0]                  debug_timestamp,
  output logic [1:0]                   trace_state,
  output logic                         triggered,
  output logic [AW-1:0]                trig_addr,
  output logic                         wrapped,
  output logic [15:0]                  dedup_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [SW-1:0]        rr_q, gnt_idx, cand, rr_next;
  logic                 gnt_any;
  logic [2:0]           gnt_id;
  logic [PAYLOAD_W-1:0] gnt_payload;
  logic                 capturing, accept, is_dup, do_write, hit, arm_go, post_last;
  logic [AW-1:0]        ptr_q, post_cnt_q, trig_addr_q, waddr_q;
  logic [31:0]          ts_q;
  logic [63:0]          wdata_q;
  logic                 we_q, triggered_q, wrapped_q;

  function automatic logic [SW-1:0] rr_index(input int base, input int k);
    int t;
    t = base + k;
    if (t >= NUM_SRC) t = t - NUM_SRC;
    return SW'(t);
  endfunction

  // First valid source at or after the round-robin pointer; with nothing valid the pointer
  // position itself holds the single grant.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = rr_q;
    cand    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = rr_index(int'(rr_q), k);
      if (!gnt_any && src_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign rr_next     = rr_index(int'(gnt_idx), 1);
  assign gnt_id      = 3'(gnt_idx);
  assign gnt_payload = src_data[int'(gnt_idx)*PAYLOAD_W +: PAYLOAD_W];

  assign capturing = (state_q == ST_ARMED) || (state_q == ST_POST);
  assign accept    = capturing && gnt_any;
  assign do_write  = accept && !is_dup;
  assign hit       = |(trig_events & debug_trigger_mask);
  assign arm_go    = arm && debug_capture_enable && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign post_last = (post_cnt_q + AW'(1)) == post_trig_len;

  always_comb begin
    src_ready = '0;
    if (resetn) begin
      if (capturing) src_ready[gnt_idx] = 1'b1;
      else           src_ready = '1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (arm_go) state_d = ST_ARMED;
      ST_ARMED: if (hit) state_d = (post_trig_len == '0) ? ST_DONE : ST_POST;
      ST_POST:  if (do_write && post_last) state_d = ST_DONE;
      ST_DONE:  if (arm_go) state_d = ST_ARMED;
      default:  state_d = ST_IDLE;
    endcase
    // Losing enable overrides everything, including a same-cycle arm.
    if (!debug_capture_enable) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      rr_q        <= '0;
      ts_q        <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      ptr_q       <= '0;
      post_cnt_q  <= '0;
      trig_addr_q <= '0;
      triggered_q <= 1'b0;
      wrapped_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_q + 32'd1;
      we_q    <= do_write;
      if (do_write) begin
        waddr_q <= ptr_q;
        wdata_q <= {ts_q, gnt_id, 5'b0, 24'(gnt_payload)};
      end
      if (accept) rr_q <= rr_next;
      if (arm_go) begin
        ptr_q       <= '0;
        post_cnt_q  <= '0;
        trig_addr_q <= '0;
        triggered_q <= 1'b0;
        wrapped_q   <= 1'b0;
      end else begin
        if (do_write) begin
          ptr_q <= ptr_q + AW'(1);
          if (ptr_q == AW'(DEPTH-1)) wrapped_q <= 1'b1;
          if (state_q == ST_POST) post_cnt_q <= post_cnt_q + AW'(1);
        end
        // An entry accepted in the trigger cycle is pre-trigger history.
        if (state_q == ST_ARMED && hit) begin
          triggered_q <= 1'b1;
          trig_addr_q <= ptr_q + AW'(do_write);
        end
      end
    end
  end

`ifdef UCIE_DEBUG_TRACE_DEDUP_EN
  logic                 last_vld_q;
  logic [2:0]           last_id_q;
  logic [PAYLOAD_W-1:0] last_pl_q;
  logic [15:0]          dedup_q;

  assign is_dup = last_vld_q && (last_id_q == gnt_id) && (last_pl_q == gnt_payload);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_vld_q <= 1'b0;
      last_id_q  <= '0;
      last_pl_q  <= '0;
      dedup_q    <= '0;
    end else if (arm_go) begin
      last_vld_q <= 1'b0;
      dedup_q    <= '0;
    end else begin
      if (do_write) begin
        last_vld_q <= 1'b1;
        last_id_q  <= gnt_id;
        last_pl_q  <= gnt_payload;
      end
      if (accept && is_dup && dedup_q != 16'hFFFF) dedup_q <= dedup_q + 16'd1;
    end
  end

  assign dedup_count = dedup_q;
`else
  assign is_dup      = 1'b0;
  assign dedup_count = '0;
`endif

  assign buf_we          = we_q;
  assign buf_waddr       = waddr_q;
  assign buf_wdata       = wdata_q;
  assign debug_trace_ptr = ptr_q;
  assign debug_timestamp = ts_q;
  assign trace_state     = state_q;
  assign triggered       = triggered_q;
  assign trig_addr       = trig_addr_q;
  assign wrapped         = wrapped_q;

endmodule

// File: tb/tb_ucie_debug_trace_ctrl.sv
// Directed bench for ucie_debug_trace_ctrl: arbitration vector table plus hand-written
// capture sequences (wrap, trigger, post window, enable drop, reset, dedup).
module tb_ucie_debug_trace_ctrl;
  localparam int NUM_SRC   = 4;
  localparam int DEPTH     = 256;
  localparam int PAYLOAD_W = 24;
  localparam int AW        = 8;

  logic                         clk = 1'b0;
  logic                         resetn;
  logic                         debug_capture_enable;
  logic [31:0]                  debug_trigger_mask;
  logic [31:0]                  trig_events;
  logic                         arm;
  logic [AW-1:0]                post_trig_len;
  logic [NUM_SRC-1:0]           src_valid;
  logic [NUM_SRC*PAYLOAD_W-1:0] src_data;
  logic [NUM_SRC-1:0]           src_ready;
  logic                         buf_we;
  logic [AW-1:0]                buf_waddr;
  logic [63:0]                  buf_wdata;
  logic [AW-1:0]                debug_trace_ptr;
  logic [31:0]                  debug_timestamp;
  logic [1:0]                   trace_state;
  logic                         triggered;
  logic [AW-1:0]                trig_addr;
  logic                         wrapped;
  logic [15:0]                  dedup_count;

  ucie_debug_trace_ctrl #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clk(clk), .resetn(resetn), .debug_capture_enable(debug_capture_enable),
    .debug_trigger_mask(debug_trigger_mask), .trig_events(trig_events), .arm(arm),
    .post_trig_len(post_trig_len), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
    .debug_trace_ptr(debug_trace_ptr), .debug_timestamp(debug_timestamp),
    .trace_state(trace_state), .triggered(triggered), .trig_addr(trig_addr),
    .wrapped(wrapped), .dedup_count(dedup_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [63:0] data; } wr_t;
  wr_t wr_q[$];
  always @(negedge clk) if (buf_we) wr_q.push_back('{buf_waddr, buf_wdata});

  // Reference cycle count: zero in reset, +1 every clock afterwards.
  logic [31:0] ts_model;
  always @(posedge clk) begin
    if (!resetn) ts_model <= '0;
    else         ts_model <= ts_model + 32'd1;
  end

  typedef struct packed { logic [3:0] valid; logic [3:0] exp_ready; } arb_vec_t;
  arb_vec_t tbl [12];

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_ts [10];
  int exp_id[$];
  int exp_pl[$];
  int n0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [23:0] v);
    src_data[i*PAYLOAD_W +: PAYLOAD_W] = v;
  endtask

  task automatic do_arm();
    debug_capture_enable = 1'b1;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // Round-robin pointer is 1 when the table starts (previous accepts all from source 0).
    tbl[0]  = '{4'b1111, 4'b0010};
    tbl[1]  = '{4'b1111, 4'b0100};
    tbl[2]  = '{4'b1111, 4'b1000};
    tbl[3]  = '{4'b1111, 4'b0001};
    tbl[4]  = '{4'b1010, 4'b0010};
    tbl[5]  = '{4'b1010, 4'b1000};
    tbl[6]  = '{4'b0001, 4'b0001};
    tbl[7]  = '{4'b0000, 4'b0010};
    tbl[8]  = '{4'b0001, 4'b0001};
    tbl[9]  = '{4'b1100, 4'b0100};
    tbl[10] = '{4'b0110, 4'b0010};
    tbl[11] = '{4'b0110, 4'b0100};

    resetn = 1'b0; debug_capture_enable = 1'b0; debug_trigger_mask = '0; trig_events = '0;
    arm = 1'b0; post_trig_len = '0; src_valid = '0; src_data = '0;
    tick(); tick();
    chk("rst_state", trace_state, 0);
    chk("rst_ptr", debug_trace_ptr, 0);
    chk("rst_we", buf_we, 0);
    chk("rst_ready", src_ready, 0);
    chk("rst_ts", debug_timestamp, 0);
    chk("rst_trig", triggered, 0);
    chk("rst_wrapped", wrapped, 0);
    chk("rst_dedup", dedup_count, 0);

    resetn = 1'b1;
    tick();
    chk("idle_ready", src_ready, 4'hF);
    chk("ts_first", debug_timestamp, 1);
    tick(); tick(); tick();
    chk("ts_count", debug_timestamp, 4);

    // Source 0 streams payloads 0..9.
    do_arm();
    chk("arm_state", trace_state, 1);
    chk("arm_ptr", debug_trace_ptr, 0);
    wr_q.delete();
    for (int k = 0; k < 10; k++) begin
      src_valid = 4'b0001;
      set_lane(0, 24'(k));
      exp_ts[k] = ts_model;
      tick();
    end
    src_valid = '0;
    tick(); tick();
    chk("t1_nwr", wr_q.size(), 10);
    for (int k = 0; k < 10 && k < wr_q.size(); k++) begin
      chk("t1_addr", wr_q[k].addr, k);
      chk("t1_payload", wr_q[k].data[23:0], k);
      chk("t1_id", wr_q[k].data[31:29], 0);
      chk("t1_zero", wr_q[k].data[28:24], 0);
      chk("t1_ts", wr_q[k].data[63:32], exp_ts[k]);
    end
    chk("t1_state", trace_state, 1);

    // Arbitration vectors.
    wr_q.delete();
    for (int s = 0; s < 12; s++) begin
      src_valid = tbl[s].valid;
      for (int i = 0; i < NUM_SRC; i++) set_lane(i, {8'(i), 16'(s)});
      #1;
      chk("arb_ready", src_ready, tbl[s].exp_ready);
      for (int i = 0; i < NUM_SRC; i++)
        if (tbl[s].valid[i] && tbl[s].exp_ready[i]) begin
          exp_id.push_back(i);
          exp_pl.push_back({8'(i), 16'(s)});
        end
      tick();
    end
    src_valid = '0;
    tick(); tick();
    chk("arb_nwr", wr_q.size(), exp_id.size());
    for (int j = 0; j < exp_id.size() && j < wr_q.size(); j++) begin
      chk("arb_id", wr_q[j].data[31:29], exp_id[j]);
      chk("arb_payload", wr_q[j].data[23:0], exp_pl[j]);
      chk("arb_addr", wr_q[j].addr, 10 + j);
    end
    chk("arb_ptr", debug_trace_ptr, 21);

    // Enable drop from ARMED, then re-arm.
    debug_capture_enable = 1'b0;
    tick();
    chk("drop_state", trace_state, 0);
    chk("drop_ready", src_ready, 4'hF);
    chk("drop_ptr", debug_trace_ptr, 21);
    do_arm();
    chk("rearm_ptr", debug_trace_ptr, 0);

    // 300 entries without trigger: wrap.
    for (int k = 0; k < 300; k++) begin
      src_valid = 4'b0100;
      set_lane(2, 24'(k));
      tick();
      if (k == 254) begin
        chk("pre_wrap_flag", wrapped, 0);
        chk("pre_wrap_ptr", debug_trace_ptr, 255);
      end
    end
    src_valid = '0;
    tick();
    chk("wrap_flag", wrapped, 1);
    chk("wrap_ptr", debug_trace_ptr, 44);

    // Zero mask and unmasked event never fire.
    debug_trigger_mask = '0;
    trig_events = 32'hFFFF_FFFF;
    tick(); tick(); tick();
    chk("zmask_state", trace_state, 1);
    chk("zmask_trig", triggered, 0);
    debug_trigger_mask = 32'h20;
    trig_events = 32'h10;
    tick();
    chk("unmasked_state", trace_state, 1);

    post_trig_len = 8'd16;
    trig_events = 32'h20;
    tick();
    trig_events = '0;
    chk("trig_state", trace_state, 2);
    chk("trig_flag", triggered, 1);
    chk("trig_addr", trig_addr, 44);
    wr_q.delete();
    for (int k = 0; k < 30; k++) begin
      src_valid = 4'b1000;
      set_lane(3, 24'h3000 + 24'(k));
      tick();
    end
    #1;
    chk("done_ready", src_ready, 4'hF);
    src_valid = '0;
    tick(); tick();
    chk("post_nwr", wr_q.size(), 16);
    for (int j = 0; j < 16 && j < wr_q.size(); j++) chk("post_addr", wr_q[j].addr, 44 + j);
    chk("post_state", trace_state, 3);
    chk("post_ptr", debug_trace_ptr, 60);
    chk("post_trig_addr", trig_addr, 44);
    chk("post_wrapped", wrapped, 1);

    // Trigger coincident with an accept at ptr 7, zero post window.
    do_arm();
    wr_q.delete();
    for (int k = 0; k < 7; k++) begin
      src_valid = 4'b0001;
      set_lane(0, 24'h500 + 24'(k));
      tick();
    end
    set_lane(0, 24'h777);
    post_trig_len = '0;
    trig_events = 32'h20;
    tick();
    trig_events = '0;
    src_valid = '0;
    chk("coin_state", trace_state, 3);
    chk("coin_trig_addr", trig_addr, 8);
    tick();
    chk("coin_nwr", wr_q.size(), 8);
    if (wr_q.size() == 8) begin
      chk("coin_addr", wr_q[7].addr, 7);
      chk("coin_payload", wr_q[7].data[23:0], 24'h777);
    end
    chk("coin_ptr", debug_trace_ptr, 8);

    // Enable drop during POST.
    do_arm();
    post_trig_len = 8'd20;
    trig_events = 32'h20;
    tick();
    trig_events = '0;
    chk("p5_state", trace_state, 2);
    for (int k = 0; k < 5; k++) begin
      src_valid = 4'b0001;
      set_lane(0, 24'h600 + 24'(k));
      tick();
    end
    src_valid = '0;
    debug_capture_enable = 1'b0;
    tick();
    chk("pdrop_state", trace_state, 0);
    chk("pdrop_ready", src_ready, 4'hF);
    chk("pdrop_ptr", debug_trace_ptr, 5);
    n0 = wr_q.size();
    src_valid = 4'hF;
    tick(); tick(); tick();
    src_valid = '0;
    tick();
    chk("idle_no_write", wr_q.size(), n0);
    do_arm();
    chk("p5_rearm_ptr", debug_trace_ptr, 0);
    chk("p5_rearm_trig", triggered, 0);
    arm = 1'b1;
    debug_capture_enable = 1'b0;
    tick();
    arm = 1'b0;
    chk("arm_vs_drop", trace_state, 0);

    // Reset coincident with an accept drops the write.
    do_arm();
    n0 = wr_q.size();
    src_valid = 4'b0001;
    set_lane(0, 24'h777777);
    resetn = 1'b0;
    tick();
    chk("mrst_we", buf_we, 0);
    chk("mrst_state", trace_state, 0);
    src_valid = '0;
    tick();
    chk("mrst_no_write", wr_q.size(), n0);
    resetn = 1'b1;
    tick();

    // Repeated payloads from source 1.
    do_arm();
    wr_q.delete();
    src_valid = 4'b0010;
    set_lane(1, 24'hABC);
    tick(); tick(); tick();
    set_lane(1, 24'hABD);
    tick();
    src_valid = '0;
    tick(); tick();
`ifdef UCIE_DEBUG_TRACE_DEDUP_EN
    chk("dedup_nwr", wr_q.size(), 2);
    chk("dedup_count", dedup_count, 2);
    chk("dedup_ptr", debug_trace_ptr, 2);
    if (wr_q.size() == 2) chk("dedup_last", wr_q[1].data[23:0], 24'hABD);
`else
    chk("nodedup_nwr", wr_q.size(), 4);
    chk("nodedup_count", dedup_count, 0);
    chk("nodedup_ptr", debug_trace_ptr, 4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
